// File: rtl/module_arbitro_mux_4_1.sv
// Four-requester round-robin arbiter with burst limit, driving a 4:1 data mux.
// A grant is held until the owner drops its request or its burst expires.
module module_arbitro_mux_4_1 #(
  parameter int ANCHO      = 4,
  parameter int MAX_RAFAGA = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic [ANCHO-1:0] c,
  input  logic [ANCHO-1:0] d,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             valid,
  output logic [ANCHO-1:0] out
);

  localparam int CW = $clog2(MAX_RAFAGA);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_RAFAGA - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          r_state;
  logic [3:0]      r_gnt;
  logic [1:0]      r_sel;
  logic            r_valid;
  logic [1:0]      r_ptr;
  logic [CW-1:0]   r_cnt;

  logic            w_any;
  logic            w_release;
  logic [1:0]      w_ptr_nxt;
  logic [1:0]      w_pick_idle;
  logic [1:0]      w_pick_rel;
  logic [ANCHO-1:0] w_mux;

  // First set request at or after start, scanning start, start+1, ... mod 4.
  function automatic logic [1:0] f_pick(input logic [3:0] req_v, input logic [1:0] start);
    logic [1:0] idx;
    f_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req_v[idx]) f_pick = idx;
    end
  endfunction

  assign w_any       = |req;
  assign w_release   = ~req[r_sel] | (r_cnt == CNT_MAX);
  assign w_ptr_nxt   = r_sel + 2'd1;
  assign w_pick_idle = f_pick(req, r_ptr);
  assign w_pick_rel  = f_pick(req, w_ptr_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= GRANT;
            r_sel   <= w_pick_idle;
            r_gnt   <= 4'b0001 << w_pick_idle;
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            // Re-arbitrate on the release edge itself so owners hand over without a gap.
            r_ptr <= w_ptr_nxt;
            r_cnt <= '0;
            if (w_any) begin
              r_sel <= w_pick_rel;
              r_gnt <= 4'b0001 << w_pick_rel;
            end else begin
              r_state <= IDLE;
              r_gnt   <= 4'b0000;
              r_valid <= 1'b0;
            end
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 4'b0000;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_mux = a;
    case (r_sel)
      2'd0:    w_mux = a;
      2'd1:    w_mux = b;
      2'd2:    w_mux = c;
      default: w_mux = d;
    endcase
  end

  assign out   = r_valid ? w_mux : '0;
  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = r_valid;

endmodule

// File: doc/module_arbitro_mux_4_1.md
MODULE_ARBITRO_MUX_4_1 -- requirements
Module: module_arbitro_mux_4_1

Interface
REQ-001 The block SHALL have parameter ANCHO, default 4: width of each data input and of out.
REQ-002 The block SHALL have parameter MAX_RAFAGA, default 8, legal range 2..255: maximum consecutive cycles one requester may hold the grant.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req, input, 4 bits: request lines; bit 0 = a, bit 1 = b, bit 2 = c, bit 3 = d.
REQ-006 The block SHALL have ports a, b, c and d, input, ANCHO bits each: requester data.
REQ-007 The block SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-008 The block SHALL have port sel, output, 2 bits: index of current owner, registered.
REQ-009 The block SHALL have port valid, output, 1 bit: high while any grant is active, registered.
REQ-010 The block SHALL have port out, output, ANCHO bits: selected data, combinational from sel and a..d, gated by valid.

Function
REQ-011 The block SHALL implement FSM states IDLE (no owner) and GRANT (one owner).
REQ-012 In IDLE with req != 0, the block SHALL enter GRANT at the next edge with owner = first set req bit at or after ptr, searching ptr, ptr+1, ... mod 4; the grant latency is 1 cycle.
REQ-013 In IDLE with req == 0, the block SHALL remain in IDLE with gnt = 0 and valid = 0.
REQ-014 In GRANT, the block SHALL keep gnt = 1 << sel, valid = 1 and out = the selected input (00->a, 01->b, 10->c, 11->d), following input changes in the same cycle.
REQ-015 When valid = 0, the block SHALL drive out = 0.
REQ-016 A 3-bit counter cnt SHALL be cleared on every new grant (including a re-grant) and increment each cycle in GRANT, saturating at MAX_RAFAGA-1.
REQ-017 Release SHALL occur at the edge where req[sel] = 0, or where cnt == MAX_RAFAGA-1.
REQ-018 On release, ptr SHALL become sel+1 mod 4 (wrapping 3 -> 0), and re-arbitration SHALL happen at that same edge using the new ptr with no idle bubble.
REQ-019 In re-arbitration, if no req bit is set, the block SHALL go to IDLE.
REQ-020 If the only requester is the expiring owner, the block SHALL re-grant it with cnt cleared.
REQ-021 Requests that rise or fall on non-owner lines during GRANT SHALL have no effect until the next release.
REQ-022 gnt SHALL never have more than one bit set, and sel SHALL change only on a grant edge.
REQ-023 cnt SHALL be log2-sized for MAX_RAFAGA-1; this clause overrides the 3-bit width in REQ-016 for MAX_RAFAGA > 8.

Reset
REQ-024 While rst = 1, the block SHALL immediately force state IDLE, gnt = 0, sel = 0, valid = 0, out = 0, ptr = 0 and cnt = 0, independent of clk.
REQ-025 Reset asserted mid-burst SHALL drop the grant immediately with no completion.
REQ-026 After rst deasserts, the first arbitration SHALL start from ptr = 0.

Verification
REQ-027 The bench SHALL cover reset then a single requester: rst pulse, req = 0001, a = 4'hA -> one edge later gnt = 0001, sel = 00, valid = 1, out = 4'hA; sweep a 0..15, out follows in the same cycle.
REQ-028 The bench SHALL cover round-robin order: req = 1111 held, MAX_RAFAGA = 8 -> grants a, b, c, d, a for 8 cycles each, with no gap cycle between owners.
REQ-029 The bench SHALL cover early release: owner b, req[1] drops after 3 cycles, req = 1001 -> next edge gnt = 1000 (d), since ptr = 2 searches c then d.
REQ-030 The bench SHALL cover wrap and re-grant: only req[3] held for 20 cycles -> sel = 11 for all cycles, cnt restarts every 8, and valid never drops.
REQ-031 The bench SHALL cover reset mid-burst: rst asserted between edges during an owner-c burst -> gnt, valid and out = 0 at once; after release with req = 0100, c is granted one edge later.
REQ-032 The bench SHALL cover idle: req = 0000 for 10 cycles -> valid = 0, out = 0 and gnt = 0 throughout, while data inputs toggle.
